// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Purpose  : N-master AXI read-channel arbiter. Grants AR requests round-robin
//            into a single-entry output register, tags them with {MID, local
//            id}, tracks per-master outstanding reads against a credit limit,
//            and routes R beats back to their master by MID.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 64,
   parameter int LID_W       = 2,
   parameter int MAX_OUTST   = 4,
   localparam int MID_W      = $clog2(NUM_MASTERS),
   localparam int GID_W      = MID_W + LID_W,
   localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
   input  logic                          CLK,
   input  logic                          RST,
   // upstream AR
   input  logic [NUM_MASTERS-1:0]        m_arvalid,
   output logic [NUM_MASTERS-1:0]        m_arready,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
   input  logic [NUM_MASTERS*LID_W-1:0]  m_arid,
   input  logic [NUM_MASTERS*4-1:0]      m_arlen,
   input  logic [NUM_MASTERS*3-1:0]      m_arsize,
   input  logic [NUM_MASTERS*2-1:0]      m_arburst,
   // upstream R
   output logic [NUM_MASTERS-1:0]        m_rvalid,
   input  logic [NUM_MASTERS-1:0]        m_rready,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [LID_W-1:0]              m_rid,
   output logic [1:0]                    m_rresp,
   output logic                          m_rlast,
   // downstream AR
   output logic                          s_arvalid,
   input  logic                          s_arready,
   output logic [ADDR_W-1:0]             s_araddr,
   output logic [GID_W-1:0]              s_arid,
   output logic [3:0]                    s_arlen,
   output logic [2:0]                    s_arsize,
   output logic [1:0]                    s_arburst,
   // downstream R
   input  logic                          s_rvalid,
   output logic                          s_rready,
   input  logic [DATA_W-1:0]             s_rdata,
   input  logic [GID_W-1:0]              s_rid,
   input  logic [1:0]                    s_rresp,
   input  logic                          s_rlast,
   // debug / status
   output logic [NUM_MASTERS*CNT_W-1:0]  outst_cnt,
   output logic                          err_bad_mid
);

   typedef enum logic {AR_EMPTY = 1'b0, AR_FULL = 1'b1} ar_state_t;

   ar_state_t                ar_state;
   ar_state_t                ar_state_next;
   logic [MID_W-1:0]         rr_ptr;
   logic [NUM_MASTERS-1:0]   eligible;
   logic [NUM_MASTERS-1:0]   rlast_hs;
   logic                     found;
   logic [MID_W-1:0]         winner;
   logic [MID_W-1:0]         scan_idx;
   logic                     drain;
   logic                     can_load;
   logic                     grant;
   logic [ADDR_W-1:0]        sel_addr;
   logic [LID_W-1:0]         sel_lid;
   logic [3:0]               sel_len;
   logic [2:0]               sel_size;
   logic [1:0]               sel_burst;
   logic [MID_W-1:0]         r_mid;
   logic                     bad_mid;

   assign s_arvalid = (ar_state == AR_FULL);
   assign drain     = (ar_state == AR_FULL) && s_arready;
   assign can_load  = (ar_state == AR_EMPTY) || drain;
   // No grant is visible while reset is held, even though m_arready is combinational.
   assign grant     = can_load && found && !RST;

   // Round-robin search: first eligible master at or after rr_ptr, wrapping.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         scan_idx = MID_W'((int'(rr_ptr) + k) % NUM_MASTERS);
         if (!found && eligible[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   // Select the winning master's AR payload.
   always_comb begin
      sel_addr  = '0;
      sel_lid   = '0;
      sel_len   = '0;
      sel_size  = '0;
      sel_burst = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (winner == MID_W'(i)) begin
            sel_addr  = m_araddr[i*ADDR_W +: ADDR_W];
            sel_lid   = m_arid[i*LID_W +: LID_W];
            sel_len   = m_arlen[i*4 +: 4];
            sel_size  = m_arsize[i*3 +: 3];
            sel_burst = m_arburst[i*2 +: 2];
         end
      end
   end

   // AR output register state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) ar_state <= AR_EMPTY;
      else     ar_state <= ar_state_next;
   end

   // AR register next state: fill on grant, empty on drain unless refilled.
   always_comb begin
      ar_state_next = ar_state;
      case (ar_state)
         AR_EMPTY: if (grant)           ar_state_next = AR_FULL;
         AR_FULL:  if (drain && !grant) ar_state_next = AR_EMPTY;
         default:                       ar_state_next = AR_EMPTY;
      endcase
   end

   // AR payload capture; held stable until the register is drained.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s_araddr  <= '0;
         s_arid    <= '0;
         s_arlen   <= '0;
         s_arsize  <= '0;
         s_arburst <= '0;
      end else if (grant) begin
         s_araddr  <= sel_addr;
         s_arid    <= {winner, sel_lid};
         s_arlen   <= sel_len;
         s_arsize  <= sel_size;
         s_arburst <= sel_burst;
      end
   end

   // Round-robin pointer moves past the winner on every grant.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)        rr_ptr <= '0;
      else if (grant) rr_ptr <= (winner == MID_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
   end

   // R routing: MID field of the global id selects the master.
   assign r_mid   = s_rid[GID_W-1:LID_W];
   assign m_rid   = s_rid[LID_W-1:0];
   assign m_rdata = s_rdata;
   assign m_rresp = s_rresp;
   assign m_rlast = s_rlast;

   if ((1 << MID_W) > NUM_MASTERS) begin : g_mid_check
      assign bad_mid = (r_mid > MID_W'(NUM_MASTERS - 1));
   end else begin : g_mid_full
      assign bad_mid = 1'b0;
   end

   // Downstream ready follows the addressed master; unknown MIDs are sunk.
   always_comb begin
      s_rready = 1'b1;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_mid == MID_W'(i)) s_rready = m_rready[i];
      end
   end

   // One pulse per beat dropped for carrying an unknown MID.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) err_bad_mid <= 1'b0;
      else     err_bad_mid <= s_rvalid && bad_mid;
   end

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
      logic [CNT_W-1:0] cnt;
      logic             inc;
      logic             dec;

      assign eligible[i] = m_arvalid[i] && (cnt < CNT_W'(MAX_OUTST));
      assign inc         = grant && (winner == MID_W'(i));
      assign m_arready[i] = inc;
      assign m_rvalid[i] = s_rvalid && (r_mid == MID_W'(i));
      assign rlast_hs[i] = m_rvalid[i] && m_rready[i] && s_rlast;
      assign dec         = rlast_hs[i];
      assign outst_cnt[i*CNT_W +: CNT_W] = cnt;

      // Outstanding-read credit counter, saturating at both ends.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            cnt <= '0;
         end else if (inc && !dec) begin
            if (cnt < CNT_W'(MAX_OUTST)) cnt <= cnt + 1'b1;
         end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Parametrised N-master AXI read-channel arbiter and response router placed between the bus masters (I$, D$, SP0, SP1, and future units) and the single downstream AXI slave port. It arbitrates AR requests round-robin, tags each with a global `{MID, local id}` identifier, and tracks per-master outstanding reads with credit limits. It also routes R beats back to their master by the MID field. It generalises the fixed 4-master / 2-bit-ID read path to any master count, ID width and outstanding depth.

## Interface
- `NUM_MASTERS`, 4: number of upstream masters (≥2).
- `ADDR_W`, 32: AR address width.
- `DATA_W`, 64: R data width.
- `LID_W`, 2: local (per-master) ID width.
- `MAX_OUTST`, 4: maximum outstanding reads per master (1..2^LID_W).
- `MID_W`, derived: `$clog2(NUM_MASTERS)`; global ID width `GID_W = MID_W + LID_W`.

- `CLK` in 1: single clock. One clock; reset is asynchronous and active-high.
- `RST` in 1: asynchronous, active-high reset.
- `m_arvalid` in NUM_MASTERS: per-master AR valid.
- `m_arready` out NUM_MASTERS: per-master AR ready.
- `m_araddr` in NUM_MASTERS×ADDR_W: AR address.
- `m_arid` in NUM_MASTERS×LID_W: local ID.
- `m_arlen` in NUM_MASTERS×4, `m_arsize` in NUM_MASTERS×3, `m_arburst` in NUM_MASTERS×2: burst attributes.
- `m_rvalid` out NUM_MASTERS: per-master R valid.
- `m_rready` in NUM_MASTERS: per-master R ready.
- `m_rdata` out DATA_W, `m_rid` out LID_W, `m_rresp` out 2, `m_rlast` out 1: R payload, shared by all masters and qualified by `m_rvalid`.
- `s_arvalid` out 1, `s_arready` in 1: downstream AR handshake.
- `s_araddr` out ADDR_W, `s_arid` out GID_W, `s_arlen` out 4, `s_arsize` out 3, `s_arburst` out 2: downstream AR payload.
- `s_rvalid` in 1, `s_rready` out 1: downstream R handshake.
- `s_rdata` in DATA_W, `s_rid` in GID_W, `s_rresp` in 2, `s_rlast` in 1: downstream R payload.
- `outst_cnt` out NUM_MASTERS×$clog2(MAX_OUTST+1): per-master outstanding count (debug).
- `err_bad_mid` out 1: one-cycle pulse when an R beat carries MID ≥ NUM_MASTERS.

## Operation
- **AR output register.** A single-entry register holds the granted request. States: EMPTY and FULL.
  - EMPTY→FULL on grant.
  - FULL→EMPTY on `s_arvalid && s_arready`.
  - FULL→FULL (drain and refill in the same cycle) is allowed when a grant occurs in the same cycle as the drain.
- **Eligibility.** Master i is eligible when `m_arvalid[i]` is high and `outst_cnt[i] < MAX_OUTST`.
- **Grant.** A grant occurs when the register is EMPTY or draining this cycle and at least one master is eligible.
  - Winner is the first eligible master at or after `rr_ptr`, wrapping modulo NUM_MASTERS.
  - `m_arready[winner]` is high combinationally in that cycle. All other `m_arready` bits are low.
  - `rr_ptr` becomes `(winner+1) mod NUM_MASTERS`. It is unchanged when no grant occurs.
- **ID tagging.** `s_arid = {winner[MID_W-1:0], m_arid[winner]}`. All other fields pass through unchanged.
- **Credit counters.**
  - `outst_cnt[i]` increments on master i's AR grant.
  - It decrements on an R handshake to master i with `m_rlast` set.
  - Increment and decrement in the same cycle leaves the count unchanged.
  - The counter never exceeds MAX_OUTST and never underflows. An rlast arriving with count 0 is a protocol error: the count holds at 0.
- **R routing.**
  - `mid = s_rid[GID_W-1:LID_W]`.
  - `m_rvalid[mid] = s_rvalid`; all other `m_rvalid` bits are 0.
  - `s_rready = m_rready[mid]`.
  - `m_rid = s_rid[LID_W-1:0]`. Data, resp and last are broadcast.
  - Routing is purely combinational, with no R buffering.
- **Unknown MID.** If `mid ≥ NUM_MASTERS`: `s_rready = 1` (the beat is dropped), no `m_rvalid` is asserted, and `err_bad_mid` pulses for each dropped beat.

## Timing
- **Reset values.**
  - AR register EMPTY.
  - `s_arvalid` 0 and all `s_ar*` payload outputs 0.
  - `rr_ptr` 0.
  - `outst_cnt` all 0.
  - `err_bad_mid` 0.
  - `m_arready` 0. It is combinational, but no master is eligible to be granted in a way visible downstream until after reset.
- **Reset mid-operation.** Outstanding state is discarded immediately, and `s_arvalid` drops asynchronously.
- **AR latency.** 1 cycle from master handshake to `s_arvalid`. With `s_arready` held high, throughput is 1 request/cycle.
- **AR stability.** `s_ar*` remains stable while `s_arvalid && !s_arready`.
- **R latency.** 0 cycles: combinational pass-through.
- **Credit visibility.** A decrement is visible to eligibility in the cycle after the rlast handshake.

## Test plan
- **Round-robin fairness.** After reset, all 4 masters hold `arvalid` with `s_arready` = 1 → grants in order 0,1,2,3,0. `s_arid` MID bits follow 0,1,2,3, and one grant issues per cycle.
- **Credit limit.** MAX_OUTST = 4, and master 2 issues 5 requests with no R traffic → exactly 4 grants. `outst_cnt[2]` = 4 and `m_arready[2]` stays 0. After one rlast beat to MID 2, the 5th request is granted the following cycle.
- **Backpressure.** `s_arready` = 0 for 3 cycles with master 1 requesting addr 0x1000 → `s_araddr` holds 0x1000 and no new grant occurs. When `s_arready` = 1, the request drains and the next grant occurs in the same cycle.
- **R routing.** 4-beat burst with `s_rid` = {2'b11, 2'b01} → only `m_rvalid[3]` is asserted and `m_rid` = 1. With `m_rready[3]` toggled low, `s_rready` follows it. `outst_cnt[3]` decrements once, after the last beat only.
- **Simultaneous events.** A grant to master 0 and an rlast to master 0 in the same cycle → `outst_cnt[0]` is unchanged.
- **Bad MID and reset.** NUM_MASTERS = 3 with an R beat whose MID = 3 → `s_rready` = 1, no `m_rvalid`, and a one-cycle `err_bad_mid` pulse. Asserting RST mid-burst → `s_arvalid` = 0 and all counters 0 immediately.
